vga_timing_gen_param: RTL

- Parametrised VGA timing and pixel-fetch engine for the display path.
- Runs on the single system clock CLK and derives a pixel-rate clock enable internally. No derived clock is generated.
- Generates HS, VS and DE for any mode supplied by parameters.
- Issues scaled frame-buffer addresses and absorbs a configurable frame-buffer read latency.
- Maps PIX_W-bit pixels through a writable 8-bit palette.

---
 rtl/vga_timing_gen_param.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen_param.sv
// VGA timing generator and pixel-fetch engine for any parameter-defined mode.
// A pixel-rate enable is derived from CLK; X/Y counters issue scaled frame-buffer
// addresses, and the region flags are delayed to match the frame-buffer latency
// so that the syncs, DE and the palette-mapped colour reach the pins together.
module vga_timing_gen_param #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 29,
   parameter int unsigned HS_POL      = 0,
   parameter int unsigned VS_POL      = 0,
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned FB_W_BITS   = 8,
   parameter int unsigned FB_H_BITS   = 7,
   parameter int unsigned PIX_W       = 1,
   parameter int unsigned RD_LAT      = 1
) (
   input  logic                           CLK,
   input  logic                           RESET,
   output logic                           PIX_CE,
   output logic [FB_W_BITS+FB_H_BITS-1:0] FB_ADDR,
   input  logic [PIX_W-1:0]               FB_DATA,
   input  logic                           PAL_WE,
   input  logic [PIX_W-1:0]               PAL_ADDR,
   input  logic [7:0]                     PAL_DATA,
   output logic                           VGA_HS,
   output logic                           VGA_VS,
   output logic                           VGA_DE,
   output logic [7:0]                     VGA_COLOUR,
   output logic                           FRAME_START
);

   localparam int unsigned HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned NPAL  = 1 << PIX_W;
   localparam int unsigned AW    = FB_W_BITS + FB_H_BITS;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(HT - 1);
   localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(VT - 1);
   localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYN_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYN_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic             HS_ON     = (HS_POL != 0);
   localparam logic             VS_ON     = (VS_POL != 0);

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } tag_t;

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_ce_q, pix_ce_d;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic [AW-1:0]    addr_q, addr_d;
   tag_t             pipe_q [RD_LAT];
   tag_t             pipe_d [RD_LAT];
   tag_t             cur, last;
   logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
   logic [7:0]       col_q, col_d;
   logic [7:0]       pal_q [NPAL];
   logic [7:0]       pal_d [NPAL];

   // Region decode of the current counter state and the oldest pipeline stage.
   always_comb begin
      cur.de = (x_q < H_ACT_END) && (y_q < V_ACT_END);
      cur.hs = (x_q >= H_SYN_BEG) && (x_q < H_SYN_END);
      cur.vs = (y_q >= V_SYN_BEG) && (y_q < V_SYN_END);
      cur.fs = (x_q == '0) && (y_q == '0);
      last   = pipe_q[RD_LAT-1];
   end

   // Next-state: divider every CLK; counters, address, delay line and pins on ticks.
   // PIX_CE is registered from the divider's next value so it stays aligned with
   // count == CLK_DIV-1 while still being a clean flop output.
   always_comb begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      pix_ce_d = (div_d == DIV_LAST);
      x_d      = x_q;
      y_d      = y_q;
      addr_d   = addr_q;
      pipe_d   = pipe_q;
      de_d     = de_q;
      hs_d     = hs_q;
      vs_d     = vs_q;
      col_d    = col_q;
      fs_d     = 1'b0;
      if (pix_ce_q) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
         end else begin
            x_d = x_q + CNT_W'(1);
         end
         addr_d    = {FB_H_BITS'(y_q >> SCALE_SHIFT), FB_W_BITS'(x_q >> SCALE_SHIFT)};
         pipe_d[0] = cur;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
         de_d  = last.de;
         hs_d  = ~(last.hs ^ HS_ON);
         vs_d  = ~(last.vs ^ VS_ON);
         col_d = last.de ? pal_q[FB_DATA] : 8'h00;
         fs_d  = last.fs;
      end
   end

   // Palette write port; lookups on the same edge see the previous contents.
   always_comb begin
      pal_d = pal_q;
      if (PAL_WE) begin
         pal_d[PAL_ADDR] = PAL_DATA;
      end
   end

   // Timing state and output registers, synchronously reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_q    <= '0;
         pix_ce_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         addr_q   <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
         de_q  <= 1'b0;
         hs_q  <= ~HS_ON;
         vs_q  <= ~VS_ON;
         col_q <= '0;
         fs_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         pix_ce_q <= pix_ce_d;
         x_q      <= x_d;
         y_q      <= y_d;
         addr_q   <= addr_d;
         pipe_q   <= pipe_d;
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         col_q    <= col_d;
         fs_q     <= fs_d;
      end
   end

   // Palette storage holds its contents through reset.
   always_ff @(posedge CLK) begin
      pal_q <= pal_d;
   end

   assign PIX_CE      = pix_ce_q;
   assign FB_ADDR     = addr_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_DE      = de_q;
   assign VGA_COLOUR  = col_q;
   assign FRAME_START = fs_q;

endmodule
